// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_e : controller state encoding (2'd3 is unused and recovers to IDLE)
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side handshake and data bus of the bit-serial adder.
//   start  : request, sampled only while ready=1
//   a, b   : operands, captured on an accepted start
//   ready  : controller idle, start will be accepted
//   busy   : serial addition in progress
//   done   : one-cycle pulse, sum/cout valid
//   sum    : a+b mod 2^WIDTH, held until the next accepted start
//   cout   : carry out of the MSB, held with sum
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
        input  ready, busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, sum, cout
    );

endinterface

// File: rtl/harf_adder.sv
// Single-bit half adder; two of these plus an OR form the shared full-adder cell.
//   in1, in2 : addend bits
//   sum      : in1 ^ in2
//   cout     : in1 & in2
module harf_adder (
    input  logic in1,
    input  logic in2,
    output logic sum,
    output logic cout
);

    assign sum  = in1 ^ in2;
    assign cout = in1 & in2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell shared over all WIDTH bit
// positions, one bit per clock, LSB first, carry kept in a register.
//   sys_clk   : system clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   bus       : requester handshake/data (slave side of serial_add_ctrl_if)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready=1, waiting for start; sum/cout hold the last result
// S_RUN  | busy=1, one bit of a+b produced per edge
// S_DONE | done=1 for exactly one cycle, then back to IDLE
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    serial_add_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic               carry_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;

    logic ha0_sum, ha0_cout;
    logic ha1_sum, ha1_cout;
    logic bit_sum_d, bit_c_d;

    harf_adder ha0 (
        .in1  (a_sh_q[0]),
        .in2  (b_sh_q[0]),
        .sum  (ha0_sum),
        .cout (ha0_cout)
    );

    harf_adder ha1 (
        .in1  (ha0_sum),
        .in2  (carry_q),
        .sum  (ha1_sum),
        .cout (ha1_cout)
    );

    assign bit_sum_d = ha1_sum;
    assign bit_c_d   = ha0_cout | ha1_cout;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_RUN;
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Result fills from the top, so after WIDTH shifts bit 0 sits at sum_q[0].
                    sum_q   <= {bit_sum_d, sum_q[WIDTH-1:1]};
                    a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
                    carry_q <= bit_c_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        cout_q  <= bit_c_d;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Status is a pure decode of the state register: start never reaches an output combinationally.
    assign bus.ready = (state_q == S_IDLE);
    assign bus.busy  = (state_q == S_RUN);
    assign bus.done  = (state_q == S_DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_fail;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        string        name;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk({name, " ready"}, 32'(ok), 32'd1);
    endtask

    // One full transaction; checks latency, busy length, result and the done pulse width.
    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input logic [W-1:0] es, input logic ec, input string name);
        int lat;
        int busy_cnt;
        wait_ready(name);
        bus.a     = ai;
        bus.b     = bi;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) busy_cnt++;
            step();
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'd8);
        chk({name, " busy cycles"}, 32'(busy_cnt), 32'd8);
        chk({name, " sum"}, 32'(bus.sum), 32'(es));
        chk({name, " cout"}, 32'(bus.cout), 32'(ec));
        step();
        chk({name, " done width"}, 32'(bus.done), 32'd0);
        chk({name, " ready after done"}, 32'(bus.ready), 32'd1);
        chk({name, " sum held"}, 32'(bus.sum), 32'(es));
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic [W:0]   model_q[$];
        logic [W:0]   exp9;
        int           acc_cyc, prev_acc, lat, done_cnt;

        n_chk  = 0;
        n_fail = 0;

        vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0, "zero"};
        vecs[1] = '{8'hA5, 8'h5A, 8'hFF, 1'b0, "a5_5a"};
        vecs[2] = '{8'hFF, 8'h01, 8'h00, 1'b1, "ripple"};
        vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b1, "msb_ovf"};
        vecs[4] = '{8'h7F, 8'h01, 8'h80, 1'b0, "7f_01"};
        vecs[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, "max"};
        vecs[6] = '{8'h01, 8'h02, 8'h03, 1'b0, "small"};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        chk("reset ready", 32'(bus.ready), 32'd1);
        chk("reset busy",  32'(bus.busy),  32'd0);
        chk("reset done",  32'(bus.done),  32'd0);
        chk("reset sum",   32'(bus.sum),   32'd0);
        chk("reset cout",  32'(bus.cout),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed table.
        for (int i = 0; i < 7; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].name);

        // start during RUN and during DONE is ignored.
        wait_ready("ignore");
        bus.a = 8'h3C; bus.b = 8'h0F; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        lat = 0;
        done_cnt = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            step();
            lat++;
            if (lat == 2) begin bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; end
            if (lat == 3) bus.start = 1'b0;
        end
        if (bus.done === 1'b1) done_cnt++;
        chk("ignore latency", 32'(lat), 32'd8);
        chk("ignore sum", 32'(bus.sum), 32'h4B);
        chk("ignore cout", 32'(bus.cout), 32'd0);
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
        step();
        bus.start = 1'b0;
        chk("ignore idle after done", 32'(bus.ready), 32'd1);
        chk("ignore no rerun", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (bus.done === 1'b1) done_cnt++;
            step();
        end
        chk("ignore single done", 32'(done_cnt), 32'd1);
        chk("ignore sum stable", 32'(bus.sum), 32'h4B);

        // Reset in the middle of RUN.
        wait_ready("midreset");
        bus.a = 8'h12; bus.b = 8'h34; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        chk("midreset busy before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset ready", 32'(bus.ready), 32'd1);
        chk("midreset busy",  32'(bus.busy),  32'd0);
        chk("midreset sum",   32'(bus.sum),   32'd0);
        chk("midreset cout",  32'(bus.cout),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done === 1'b1) done_cnt++;
        end
        chk("midreset no done", 32'(done_cnt), 32'd0);
        do_op(8'h80, 8'h80, 8'h00, 1'b1, "after_reset");

        // Random back-to-back traffic with start held high.
        wait_ready("random");
        bus.start = 1'b1;
        prev_acc  = 0;
        for (int i = 0; i < 200; i++) begin
            wait_ready("random");
            ra = W'($urandom);
            rb = W'($urandom);
            bus.a = ra;
            bus.b = rb;
            model_q.push_back({1'b0, ra} + {1'b0, rb});
            step();
            acc_cyc = cyc;
            if (i > 0) chk("random accept spacing", 32'(acc_cyc - prev_acc), 32'd10);
            prev_acc = acc_cyc;
            lat = 0;
            while (bus.done !== 1'b1 && lat < 30) begin
                step();
                lat++;
            end
            chk("random latency", 32'(lat), 32'd8);
            exp9 = model_q.pop_front();
            chk("random result", 32'({bus.cout, bus.sum}), 32'(exp9));
        end
        bus.start = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
